d_phy_hs_tx_seq: RTL and testbench

D_PHY_HS_TX_SEQ -- requirements
Module: d_phy_hs_tx_seq

---
 rtl/d_phy_hs_tx_seq.sv | 121 ++++++++++++
 tb/tb_d_phy_hs_tx_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/d_phy_hs_tx_seq.sv
// MIPI D-PHY high-speed transmit sequencer for one data lane.
// Walks LP-11 -> LP-01 -> LP-00 -> HS-0 -> sync -> payload -> trail -> LP-11.
module d_phy_hs_tx_seq #(
  parameter int HS_TX_WORD_BIT_WIDTH = 8,
  parameter int T_LPX_CYC            = 2,
  parameter int T_HS_PREPARE_CYC     = 2,
  parameter int T_HS_ZERO_CYC        = 4,
  parameter int T_HS_TRAIL_CYC       = 3,
  parameter int T_HS_EXIT_CYC        = 2
) (
  input  logic                            hs_tx_word_clk,
  input  logic                            rst,
  input  logic                            tx_request_hs,
  input  logic [HS_TX_WORD_BIT_WIDTH-1:0] tx_data_hs,
  input  logic                            tx_valid_hs,
  output logic                            tx_ready_hs,
  output logic                            lp_dp,
  output logic                            lp_dn,
  output logic                            hs_en,
  output logic [HS_TX_WORD_BIT_WIDTH-1:0] hs_data,
  output logic                            stop_state,
  output logic                            underflow
);

  localparam int W = HS_TX_WORD_BIT_WIDTH;
  localparam logic [W-1:0] SYNC_WORD = W'(8'hB8);

  typedef enum logic [2:0] {
    ST_STOP,
    ST_LPX,
    ST_PREP,
    ST_ZERO,
    ST_SYNC,
    ST_DATA,
    ST_TRAIL,
    ST_EXIT
  } state_t;

  state_t     state;
  logic [7:0] phase_cnt;
  logic       phase_done;

  // Trail drives the complement of the last serialized bit (the word's MSB).
  function automatic logic [W-1:0] trail_word(input logic [W-1:0] last_word);
    return {W{~last_word[W-1]}};
  endfunction

  always_comb begin
    phase_done = 1'b0;
    case (state)
      ST_LPX:   phase_done = (phase_cnt == 8'(T_LPX_CYC - 1));
      ST_PREP:  phase_done = (phase_cnt == 8'(T_HS_PREPARE_CYC - 1));
      ST_ZERO:  phase_done = (phase_cnt == 8'(T_HS_ZERO_CYC - 1));
      ST_TRAIL: phase_done = (phase_cnt == 8'(T_HS_TRAIL_CYC - 1));
      ST_EXIT:  phase_done = (phase_cnt == 8'(T_HS_EXIT_CYC - 1));
      default:  phase_done = 1'b0;
    endcase
  end

  always_ff @(posedge hs_tx_word_clk) begin
    if (rst) begin
      state     <= ST_STOP;
      phase_cnt <= 8'd0;
      hs_data   <= '0;
      underflow <= 1'b0;
    end else begin
      case (state)
        ST_STOP: begin
          phase_cnt <= 8'd0;
          if (tx_request_hs) begin
            state     <= ST_LPX;
            underflow <= 1'b0;
          end
        end
        ST_SYNC, ST_DATA: begin
          phase_cnt <= 8'd0;
          if (!tx_request_hs) begin
            state   <= ST_TRAIL;
            hs_data <= trail_word(hs_data);
          end else begin
            state <= ST_DATA;
            if (tx_valid_hs) hs_data   <= tx_data_hs;
            else             underflow <= 1'b1;
          end
        end
        default: begin
          // Timed phases: count to the phase length, then step to the next phase.
          if (!phase_done) begin
            phase_cnt <= phase_cnt + 8'd1;
          end else begin
            phase_cnt <= 8'd0;
            case (state)
              ST_LPX:   state <= ST_PREP;
              ST_PREP: begin
                state   <= ST_ZERO;
                hs_data <= '0;
              end
              ST_ZERO: begin
                state   <= ST_SYNC;
                hs_data <= SYNC_WORD;
              end
              ST_TRAIL: begin
                state   <= ST_EXIT;
                hs_data <= '0;
              end
              default:  state <= ST_STOP;
            endcase
          end
        end
      endcase
    end
  end

  assign lp_dp       = (state == ST_STOP) || (state == ST_EXIT);
  assign lp_dn       = (state == ST_STOP) || (state == ST_EXIT) || (state == ST_LPX);
  assign hs_en       = (state == ST_ZERO) || (state == ST_SYNC) ||
                       (state == ST_DATA) || (state == ST_TRAIL);
  assign stop_state  = (state == ST_STOP);
  assign tx_ready_hs = tx_request_hs && ((state == ST_SYNC) || (state == ST_DATA));

endmodule

// File: tb/tb_d_phy_hs_tx_seq.sv
// Bench for d_phy_hs_tx_seq: builds the expected per-cycle lane trace of each
// burst from the phase rules, then drives and compares cycle by cycle.
module tb_d_phy_hs_tx_seq;

  localparam int W       = 8;
  localparam int T_LPX   = 2;
  localparam int T_PREP  = 2;
  localparam int T_ZERO  = 4;
  localparam int T_TRAIL = 3;
  localparam int T_EXIT  = 2;
  localparam int PRE     = T_LPX + T_PREP + T_ZERO;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_request_hs;
  logic [W-1:0] tx_data_hs;
  logic         tx_valid_hs;
  logic         tx_ready_hs;
  logic         lp_dp;
  logic         lp_dn;
  logic         hs_en;
  logic [W-1:0] hs_data;
  logic         stop_state;
  logic         underflow;

  always #5 clk = ~clk;

  d_phy_hs_tx_seq #(
    .HS_TX_WORD_BIT_WIDTH(W),
    .T_LPX_CYC(T_LPX),
    .T_HS_PREPARE_CYC(T_PREP),
    .T_HS_ZERO_CYC(T_ZERO),
    .T_HS_TRAIL_CYC(T_TRAIL),
    .T_HS_EXIT_CYC(T_EXIT)
  ) dut (
    .hs_tx_word_clk(clk),
    .rst(rst),
    .tx_request_hs(tx_request_hs),
    .tx_data_hs(tx_data_hs),
    .tx_valid_hs(tx_valid_hs),
    .tx_ready_hs(tx_ready_hs),
    .lp_dp(lp_dp),
    .lp_dn(lp_dn),
    .hs_en(hs_en),
    .hs_data(hs_data),
    .stop_state(stop_state),
    .underflow(underflow)
  );

  typedef struct {
    logic         req;
    logic         vld;
    logic [W-1:0] dat;
    logic [1:0]   lp;
    logic         hsen;
    logic [W-1:0] hsd;
    logic         stop;
    logic         rdy;
    logic         uf;
  } cyc_t;

  cyc_t         q[$];
  logic         uf_m = 1'b0;
  bit           slot_vld[$];
  logic [W-1:0] slot_dat[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [W-1:0] d, input logic [1:0] lp,
                     input logic hsen, input logic [W-1:0] hsd, input logic stop, input logic rdy);
    cyc_t c;
    c.req = r; c.vld = v; c.dat = d; c.lp = lp; c.hsen = hsen;
    c.hsd = hsd; c.stop = stop; c.rdy = rdy; c.uf = uf_m;
    q.push_back(c);
  endtask

  // Expected trace of one burst: idle STOP cycles, request, timed LP/HS
  // preamble, sync, one cycle per payload slot, trail and exit.
  task automatic build(input int idle, input bit drop, input int drop_k, input bit hold);
    logic [W-1:0] disp;
    int n;
    for (int i = 0; i < idle; i++)
      add(1'b0, 1'($urandom), W'($urandom), 2'b11, 1'b0, '0, 1'b1, 1'b0);
    add(1'b1, 1'($urandom), W'($urandom), 2'b11, 1'b0, '0, 1'b1, 1'b0);
    uf_m = 1'b0;
    for (int i = 0; i < PRE; i++)
      add(drop ? 1'(i < drop_k) : 1'($urandom), 1'($urandom), W'($urandom),
          (i < T_LPX) ? 2'b01 : 2'b00, 1'(i >= T_LPX + T_PREP), '0, 1'b0, 1'b0);
    n = drop ? 0 : slot_vld.size();
    disp = 8'hB8;
    for (int j = 0; j <= n; j++) begin
      if (j < n) begin
        add(1'b1, slot_vld[j], slot_dat[j], 2'b00, 1'b1, disp, 1'b0, 1'b1);
        if (slot_vld[j]) disp = slot_dat[j];
        else             uf_m = 1'b1;
      end else begin
        add(1'b0, 1'($urandom), W'($urandom), 2'b00, 1'b1, disp, 1'b0, 1'b0);
      end
    end
    for (int i = 0; i < T_TRAIL; i++)
      add(hold ? 1'b1 : 1'($urandom), 1'($urandom), W'($urandom), 2'b00, 1'b1,
          {W{~disp[W-1]}}, 1'b0, 1'b0);
    for (int i = 0; i < T_EXIT; i++)
      add(hold ? 1'b1 : 1'($urandom), 1'($urandom), W'($urandom), 2'b11, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Plays the queued trace; at index abort_at reset is pulsed instead and the
  // rest of the burst is discarded.
  task automatic run(input int abort_at);
    cyc_t c;
    int idx;
    idx = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      if (idx == abort_at) begin
        rst = 1'b1; tx_request_hs = 1'b1; tx_valid_hs = 1'b1; tx_data_hs = W'($urandom);
        q.delete();
        uf_m = 1'b0;
        break;
      end
      rst = 1'b0; tx_request_hs = c.req; tx_valid_hs = c.vld; tx_data_hs = c.dat;
      #1;
      chk("lp_line", 32'({lp_dp, lp_dn}), 32'(c.lp));
      chk("hs_en", 32'(hs_en), 32'(c.hsen));
      chk("stop_state", 32'(stop_state), 32'(c.stop));
      chk("tx_ready_hs", 32'(tx_ready_hs), 32'(c.rdy));
      chk("underflow", 32'(underflow), 32'(c.uf));
      if (c.hsen) chk("hs_data", 32'(hs_data), 32'(c.hsd));
      idx++;
    end
  endtask

  initial begin
    bit aborted;
    int n, idle, ab;
    rst = 1'b1; tx_request_hs = 1'b1; tx_valid_hs = 1'b0; tx_data_hs = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst_lp", 32'({lp_dp, lp_dn}), 32'(2'b11));
      chk("rst_hs_en", 32'(hs_en), 32'd0);
      chk("rst_hs_data", 32'(hs_data), 32'd0);
      chk("rst_ready", 32'(tx_ready_hs), 32'd0);
      chk("rst_stop", 32'(stop_state), 32'd1);
      chk("rst_underflow", 32'(underflow), 32'd0);
    end

    slot_vld = '{1, 1, 1}; slot_dat = '{8'h11, 8'h22, 8'h83};
    build(0, 1'b0, 0, 1'b0); run(-1);
    slot_vld = '{1}; slot_dat = '{8'h05};
    build(1, 1'b0, 0, 1'b0); run(-1);
    slot_vld = '{1, 0, 1}; slot_dat = '{8'h11, 8'h00, 8'h22};
    build(0, 1'b0, 0, 1'b0); run(-1);
    build(0, 1'b1, T_LPX + T_PREP + 1, 1'b1); run(-1);
    slot_vld = '{1, 1, 1}; slot_dat = '{8'hA5, 8'h5A, 8'h3C};
    build(0, 1'b0, 0, 1'b0); run(1 + PRE + 2);
    slot_vld = '{1, 1}; slot_dat = '{8'h80, 8'h7F};
    build(1, 1'b0, 0, 1'b0); run(-1);

    aborted = 1'b0;
    for (int b = 0; b < 30; b++) begin
      n = $urandom_range(1, 6);
      slot_vld.delete(); slot_dat.delete();
      for (int s = 0; s < n; s++) begin
        slot_vld.push_back(($urandom % 4) != 0);
        slot_dat.push_back(W'($urandom));
      end
      idle = aborted ? $urandom_range(1, 2) : $urandom_range(0, 2);
      ab = -1;
      if (($urandom % 8) == 0) begin
        build(idle, 1'b1, $urandom_range(0, PRE - 1), 1'($urandom));
      end else begin
        if (n >= 2 && ($urandom % 8) == 0) ab = idle + 1 + PRE + 1 + $urandom_range(0, n - 2);
        build(idle, 1'b0, 0, 1'($urandom));
      end
      run(ab);
      aborted = (ab >= 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
